// File: rtl/tmp101_scan_scheduler.sv
// Round-robin scan scheduler for up to eight TMP101 sensors that share one I2C read unit.
// Keeps the latest reading, a valid bit and a sticky timeout flag for each sensor.
module tmp101_scan_scheduler #(
  parameter logic [19:0] PollInterval  = 20'd750000,
  parameter logic [23:0] TimeoutCycles = 24'd1500000
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [7:0] SensorMask,
  input  logic       ReadDone,
  input  logic [7:0] ReadData,
  output logic       ReadStart,
  output logic [2:0] ChipSelect,
  input  logic [2:0] SelIndex,
  output logic [7:0] SelTemp,
  output logic       SelValid,
  output logic [7:0] TimeoutFlags,
  output logic       ScanDone,
  output logic       Busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_INTERVAL
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  last;
  logic [19:0] interval_count;
  logic [23:0] timeout_count;
  logic        seen_low;
  logic [7:0]  result [8];
  logic [7:0]  valid;

  logic        pick_found;
  logic [2:0]  pick_idx;
  logic        more_above;
  logic        read_complete;
  logic        read_timeout;
  logic        interval_over;

  // Nearest enabled sensor after `from`, wrapping; distance 8 lands back on `from` itself.
  function automatic logic [3:0] pick_next(input logic [7:0] mask, input logic [2:0] from);
    logic [3:0] found;
    logic [2:0] cand;
    found = 4'd0;
    for (int d = 8; d >= 1; d--) begin
      cand = from + 3'(d);
      if (mask[cand]) found = {1'b1, cand};
    end
    return found;
  endfunction

  assign {pick_found, pick_idx} = pick_next(SensorMask, last);
  assign more_above    = |(SensorMask >> ({1'b0, last} + 4'd1));
  // DONE must be seen low after the start before a high counts, so an idle-high unit is not mistaken for done.
  assign read_complete = seen_low && ReadDone;
  assign read_timeout  = (timeout_count == TimeoutCycles - 24'd1);
  assign interval_over = (interval_count == PollInterval - 20'd1);

  assign ReadStart = (state == ST_ISSUE);
  assign Busy      = (state != ST_IDLE);
  assign SelTemp   = result[SelIndex];
  assign SelValid  = valid[SelIndex];

  always_comb begin
    // NOTE: defaults first, so every path assigns every output of this block and no latch is inferred.
    state_next = state;
    ScanDone   = 1'b0;
    case (state)
      ST_IDLE:     if (Enable && (SensorMask != 8'h00)) state_next = ST_SELECT;
      ST_SELECT:   state_next = pick_found ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:    state_next = ST_WAIT;
      ST_WAIT:     if (read_complete || read_timeout) state_next = ST_NEXT;
      ST_NEXT: begin
        if (!Enable) begin
          state_next = ST_IDLE;
        end else if (!more_above) begin
          ScanDone   = 1'b1;
          state_next = ST_INTERVAL;
        end else begin
          state_next = ST_SELECT;
        end
      end
      ST_INTERVAL: begin
        if (!Enable)            state_next = ST_IDLE;
        else if (interval_over) state_next = ST_SELECT;
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state          <= ST_IDLE;
      last           <= 3'd7;
      ChipSelect     <= 3'd0;
      interval_count <= 20'd0;
      timeout_count  <= 24'd0;
      seen_low       <= 1'b0;
      valid          <= 8'h00;
      TimeoutFlags   <= 8'h00;
      // NOTE: the result file is reset because cleared readings are visible on SelTemp, so it is built from flops, not RAM.
      for (int i = 0; i < 8; i++) result[i] <= 8'h00;
    end else begin
      state <= state_next;
      case (state)
        ST_SELECT: begin
          if (pick_found) begin
            ChipSelect <= pick_idx;
            last       <= pick_idx;
          end
        end
        ST_ISSUE: begin
          timeout_count <= 24'd0;
          seen_low      <= 1'b0;
        end
        ST_WAIT: begin
          timeout_count <= timeout_count + 24'd1;
          if (!ReadDone) seen_low <= 1'b1;
          if (read_complete) begin
            result[ChipSelect]       <= ReadData;
            valid[ChipSelect]        <= 1'b1;
            TimeoutFlags[ChipSelect] <= 1'b0;
          end else if (read_timeout) begin
            valid[ChipSelect]        <= 1'b0;
            TimeoutFlags[ChipSelect] <= 1'b1;
          end
        end
        ST_NEXT:     interval_count <= 20'd0;
        ST_INTERVAL: interval_count <= interval_count + 20'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tmp101_scan_scheduler.sv
// Directed and randomized bench for tmp101_scan_scheduler with a scripted read-unit responder
// and a per-sensor reference model of the stored results.
module tb_tmp101_scan_scheduler;

  localparam int          POLL_CYC = 10;
  localparam int          TMO_CYC  = 20;
  localparam logic [19:0] POLL     = 20'd10;
  localparam logic [23:0] TMO      = 24'd20;
  localparam int RESP_NORMAL = 0;
  localparam int RESP_NEVER  = 1;
  localparam int RESP_HIGH   = 2;

  logic       clock = 1'b0;
  logic       Reset;
  logic       Enable;
  logic [7:0] SensorMask;
  logic       ReadDone;
  logic [7:0] ReadData;
  logic       ReadStart;
  logic [2:0] ChipSelect;
  logic [2:0] SelIndex;
  logic [7:0] SelTemp;
  logic       SelValid;
  logic [7:0] TimeoutFlags;
  logic       ScanDone;
  logic       Busy;

  tmp101_scan_scheduler #(.PollInterval(POLL), .TimeoutCycles(TMO)) dut (
    .clock(clock), .Reset(Reset), .Enable(Enable), .SensorMask(SensorMask),
    .ReadDone(ReadDone), .ReadData(ReadData), .ReadStart(ReadStart),
    .ChipSelect(ChipSelect), .SelIndex(SelIndex), .SelTemp(SelTemp),
    .SelValid(SelValid), .TimeoutFlags(TimeoutFlags), .ScanDone(ScanDone), .Busy(Busy)
  );

  always #5 clock = ~clock;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Activity recorded once per cycle on the falling edge.
  int         cycle            = 0;
  int         start_count      = 0;
  int         scan_count       = 0;
  int         double_start     = 0;
  int         last_start_cycle = 0;
  int         last_scan_cycle  = 0;
  int         flag_rise_cycle  = 0;
  logic       prev_rs          = 1'b0;
  logic [7:0] prev_flags       = 8'h00;
  logic [2:0] start_cs [$];

  int         resp_mode = RESP_NORMAL;
  int         resp_low  = 3;
  logic [7:0] data_for [8];
  logic [2:0] resp_cs;

  logic [7:0] model_temp [8];
  logic       model_valid [8];
  int         model_last;
  int         exp_q [$];

  initial begin : monitor
    forever begin
      @(negedge clock);
      cycle++;
      if (ReadStart) begin
        start_count++;
        last_start_cycle = cycle;
        start_cs.push_back(ChipSelect);
        if (prev_rs) double_start++;
      end
      if (ScanDone) begin
        scan_count++;
        last_scan_cycle = cycle;
      end
      if ((TimeoutFlags & ~prev_flags) != 8'h00) flag_rise_cycle = cycle;
      prev_rs    = ReadStart;
      prev_flags = TimeoutFlags;
    end
  end

  // Read unit: DONE idles high; a normal read drops it for resp_low cycles, then raises it with data.
  initial begin : read_unit
    ReadDone = 1'b1;
    ReadData = 8'h00;
    forever begin
      @(negedge clock);
      if (ReadStart) begin
        resp_cs = ChipSelect;
        if (resp_mode == RESP_NORMAL) begin
          ReadDone = 1'b0;
          repeat (resp_low) @(negedge clock);
          ReadData = data_for[resp_cs];
          ReadDone = 1'b1;
        end else if (resp_mode == RESP_NEVER) begin
          ReadDone = 1'b0;
        end else begin
          ReadDone = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sel_check(input int idx, input logic [7:0] t, input logic v);
    SelIndex = 3'(idx);
    #1;
    check($sformatf("seltemp[%0d]", idx), 32'(SelTemp), 32'(t));
    check($sformatf("selvalid[%0d]", idx), 32'(SelValid), 32'(v));
  endtask

  function automatic logic [2:0] cs_at(input int i);
    if (i < start_cs.size()) return start_cs[i];
    return 3'bxxx;
  endfunction

  task automatic wait_start(input string tag, input int limit);
    int base;
    int n;
    base = start_count;
    n = 0;
    while (start_count == base && n < limit) begin tick(); n++; end
    check(tag, 32'(start_count != base), 32'd1);
  endtask

  task automatic wait_scan(input string tag, input int limit);
    int base;
    int n;
    base = scan_count;
    n = 0;
    while (scan_count == base && n < limit) begin tick(); n++; end
    check(tag, 32'(scan_count != base), 32'd1);
  endtask

  task automatic wait_flag(input string tag, input int idx, input int limit);
    int n;
    n = 0;
    while (!TimeoutFlags[idx] && n < limit) begin tick(); n++; end
    check(tag, 32'(TimeoutFlags[idx]), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (Busy && n < limit) begin tick(); n++; end
    check(tag, 32'(Busy), 32'd0);
  endtask

  initial begin : stimulus
    int base_s;
    int base_sc;
    int busy_hits;
    int first;
    logic [7:0] d5;
    logic [7:0] rmask;

    Reset = 1'b1; Enable = 1'b0; SensorMask = 8'h00; SelIndex = 3'd0;
    for (int i = 0; i < 8; i++) data_for[i] = 8'h00;
    repeat (3) tick();

    check("rst_busy", 32'(Busy), 0);
    check("rst_readstart", 32'(ReadStart), 0);
    check("rst_chipselect", 32'(ChipSelect), 0);
    check("rst_scandone", 32'(ScanDone), 0);
    check("rst_flags", 32'(TimeoutFlags), 0);
    for (int i = 0; i < 8; i++) sel_check(i, 8'h00, 1'b0);

    // Empty mask keeps the scheduler idle even when enabled.
    Reset = 1'b0; Enable = 1'b1; SensorMask = 8'h00;
    base_s = start_count; busy_hits = 0;
    repeat (100) begin tick(); if (Busy) busy_hits++; end
    check("t1_busy_cycles", 32'(busy_hits), 0);
    check("t1_starts", 32'(start_count - base_s), 0);

    // Two-sensor scan, then interval spacing before the next scan.
    data_for[0] = 8'd25; data_for[2] = 8'd31; resp_mode = RESP_NORMAL; resp_low = 3;
    base_s = start_count; base_sc = scan_count;
    SensorMask = 8'h05;
    wait_scan("t2_scan", 200);
    check("t2_starts", 32'(start_count - base_s), 2);
    check("t2_cs0", 32'(cs_at(base_s)), 0);
    check("t2_cs1", 32'(cs_at(base_s + 1)), 2);
    sel_check(2, 8'd31, 1'b1);
    sel_check(0, 8'd25, 1'b1);
    wait_start("t2_next_start", 60);
    check("t2_interval_gap", 32'(last_start_cycle - last_scan_cycle), 32'(POLL_CYC + 2));
    check("t2_scandone_once", 32'(scan_count - base_sc), 1);
    check("t2_next_cs", 32'(cs_at(base_s + 2)), 0);
    Enable = 1'b0;
    wait_idle("t2_drain", 60);

    // Timeout on sensor 1, then a good read clears the flag.
    resp_mode = RESP_NEVER; data_for[1] = 8'd20; SensorMask = 8'h02;
    base_sc = scan_count; Enable = 1'b1;
    wait_start("t3_start", 40);
    wait_flag("t3_timeout", 1, 60);
    resp_mode = RESP_NORMAL; resp_low = 3;
    tick();
    check("t3_tmo_latency", 32'(flag_rise_cycle - last_start_cycle), 32'(TMO_CYC + 1));
    check("t3_flags", 32'(TimeoutFlags), 32'h02);
    sel_check(1, 8'h00, 1'b0);
    wait_start("t3_retry_start", 60);
    check("t3_scan_after_timeout", 32'(scan_count - base_sc), 1);
    wait_scan("t3_retry_scan", 60);
    check("t3_flags_cleared", 32'(TimeoutFlags), 0);
    sel_check(1, 8'd20, 1'b1);
    Enable = 1'b0;
    wait_idle("t3_drain", 40);

    // DONE held high throughout: no edge, so the read must time out.
    resp_mode = RESP_HIGH; Enable = 1'b1;
    wait_start("t4_start", 40);
    wait_flag("t4_timeout", 1, 60);
    tick();
    check("t4_tmo_latency", 32'(flag_rise_cycle - last_start_cycle), 32'(TMO_CYC + 1));
    check("t4_flags", 32'(TimeoutFlags), 32'h02);
    sel_check(1, 8'd20, 1'b0);
    Enable = 1'b0;
    wait_idle("t4_drain", 40);

    // Enable dropped mid-read: the read finishes, no ScanDone, no new start.
    resp_mode = RESP_NORMAL; resp_low = 3;
    d5 = 8'($urandom); data_for[3] = d5;
    SensorMask = 8'h18; base_s = start_count; base_sc = scan_count;
    Enable = 1'b1;
    wait_start("t5_start", 40);
    Enable = 1'b0;
    wait_idle("t5_drain", 40);
    check("t5_cs", 32'(cs_at(base_s)), 3);
    check("t5_no_scandone", 32'(scan_count - base_sc), 0);
    check("t5_chipselect_held", 32'(ChipSelect), 3);
    sel_check(3, d5, 1'b1);
    sel_check(0, 8'd25, 1'b1);
    sel_check(2, 8'd31, 1'b1);
    repeat (30) tick();
    check("t5_starts", 32'(start_count - base_s), 1);

    // Reset in WAIT clears everything on the next cycle.
    resp_mode = RESP_NEVER; SensorMask = 8'h01; Enable = 1'b1;
    wait_start("t6_start", 40);
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    check("t6_busy", 32'(Busy), 0);
    check("t6_readstart", 32'(ReadStart), 0);
    check("t6_chipselect", 32'(ChipSelect), 0);
    check("t6_scandone", 32'(ScanDone), 0);
    check("t6_flags", 32'(TimeoutFlags), 0);
    for (int i = 0; i < 8; i++) sel_check(i, 8'h00, 1'b0);
    Enable = 1'b0; SensorMask = 8'h00; Reset = 1'b0;
    tick();
    check("t6_post_readstart", 32'(ReadStart), 0);
    check("t6_post_busy", 32'(Busy), 0);

    // Randomized scans against the reference model (Last = 7 after reset).
    resp_mode = RESP_NORMAL;
    model_last = 7;
    for (int i = 0; i < 8; i++) begin model_temp[i] = 8'h00; model_valid[i] = 1'b0; end
    for (int r = 0; r < 5; r++) begin
      rmask = 8'($urandom_range(1, 255));
      resp_low = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) data_for[i] = 8'($urandom);
      exp_q.delete();
      first = -1;
      for (int d = 1; d <= 8; d++)
        if (first < 0 && rmask[(model_last + d) % 8]) first = (model_last + d) % 8;
      exp_q.push_back(first);
      for (int c = first + 1; c < 8; c++) if (rmask[c]) exp_q.push_back(c);
      base_s = start_count; base_sc = scan_count;
      SensorMask = rmask; Enable = 1'b1;
      wait_scan($sformatf("r%0d_scan", r), 400);
      Enable = 1'b0;
      wait_idle($sformatf("r%0d_drain", r), 40);
      check($sformatf("r%0d_starts", r), 32'(start_count - base_s), 32'(exp_q.size()));
      check($sformatf("r%0d_scans", r), 32'(scan_count - base_sc), 1);
      for (int j = 0; j < exp_q.size(); j++) begin
        check($sformatf("r%0d_cs%0d", r, j), 32'(cs_at(base_s + j)), 32'(exp_q[j]));
        model_temp[exp_q[j]]  = data_for[exp_q[j]];
        model_valid[exp_q[j]] = 1'b1;
      end
      model_last = exp_q[exp_q.size() - 1];
      for (int i = 0; i < 8; i++) sel_check(i, model_temp[i], model_valid[i]);
      check($sformatf("r%0d_flags", r), 32'(TimeoutFlags), 0);
    end

    check("single_cycle_starts", 32'(double_start), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
